// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one block read at a time to the I-cache and
// pushes each returned block of pc/instruction pairs into the instruction queue.
module fetch_unit #(
  parameter int unsigned INSTR_FETCH_NUM = 2,
  parameter logic [31:0] RESET_PC        = 32'h1eceb000,
  parameter int unsigned WIDTH           = INSTR_FETCH_NUM * 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mispredict,
  input  logic [31:0]                  redirect_pc,
  output logic [31:0]                  imem_addr,
  output logic                         imem_req,
  input  logic [32*INSTR_FETCH_NUM-1:0] imem_rdata,
  input  logic                         imem_resp,
  output logic [WIDTH-1:0]             iq_wdata,
  output logic                         iq_push,
  input  logic                         iq_full
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pc_instr_t;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    STALL   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [31:0] BLOCK_BYTES = 32'(4 * INSTR_FETCH_NUM);

  state_t                        r_state, w_state_nxt;
  logic [31:0]                   r_pc, w_pc_nxt;
  logic [31:0]                   r_req_pc, w_req_pc_nxt;
  logic [32*INSTR_FETCH_NUM-1:0] r_hold_data, w_hold_nxt;
  logic [32*INSTR_FETCH_NUM-1:0] w_src;
  logic [31:0]                   w_target;
  logic [31:0]                   w_seq_pc;
  logic                          w_req;
  logic                          w_push;

  assign w_target = redirect_pc & ~32'h3;
  assign w_seq_pc = r_req_pc + BLOCK_BYTES;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT;
      r_pc        <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_hold_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_hold_data <= w_hold_nxt;
    end
  end

  // Mispredict is evaluated first in every state and always suppresses the push.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_pc_nxt = r_req_pc;
    w_hold_nxt   = r_hold_data;
    w_src        = imem_rdata;
    w_req        = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      WAIT: begin
        w_req = 1'b1;
        if (mispredict) begin
          w_pc_nxt = w_target;
          if (imem_resp) w_req_pc_nxt = w_target;
          else           w_state_nxt  = DISCARD;
        end else if (imem_resp) begin
          if (!iq_full) begin
            w_push       = 1'b1;
            w_pc_nxt     = w_seq_pc;
            w_req_pc_nxt = w_seq_pc;
          end else begin
            w_hold_nxt  = imem_rdata;
            w_state_nxt = STALL;
          end
        end
      end
      STALL: begin
        w_src = r_hold_data;
        if (mispredict) begin
          w_pc_nxt     = w_target;
          w_req_pc_nxt = w_target;
          w_state_nxt  = WAIT;
        end else if (!iq_full) begin
          w_push       = 1'b1;
          w_pc_nxt     = w_seq_pc;
          w_req_pc_nxt = w_seq_pc;
          w_state_nxt  = WAIT;
        end
      end
      DISCARD: begin
        // The stale request must be completed before the target can be requested.
        w_req = 1'b1;
        if (mispredict) begin
          w_pc_nxt = w_target;
        end else if (imem_resp) begin
          w_req_pc_nxt = r_pc;
          w_state_nxt  = WAIT;
        end
      end
      default: w_state_nxt = WAIT;
    endcase
  end

  always_comb begin
    iq_wdata = '0;
    if (rst_n) begin
      for (int unsigned i = 0; i < INSTR_FETCH_NUM; i++) begin
        iq_wdata[64*i +: 64] = pc_instr_t'{pc: r_req_pc + 32'(4 * i), instr: w_src[32*i +: 32]};
      end
    end
  end

  assign imem_req  = rst_n & w_req;
  assign iq_push   = rst_n & w_push;
  assign imem_addr = rst_n ? {r_req_pc[31:2], 2'b00} : RESET_PC;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: the bench plays cache and queue, and a
// stream-level model predicts requests, pushes and pushed block contents.
module tb_fetch_unit;
  localparam int unsigned N      = 2;
  localparam logic [31:0] RST_PC = 32'h1eceb000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mispredict;
  logic [31:0]   redirect_pc;
  logic [31:0]   imem_addr;
  logic          imem_req;
  logic [32*N-1:0] imem_rdata;
  logic          imem_resp;
  logic [64*N-1:0] iq_wdata;
  logic          iq_push;
  logic          iq_full;

  fetch_unit #(.INSTR_FETCH_NUM(N), .RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mispredict (mispredict),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .iq_wdata   (iq_wdata),
    .iq_push    (iq_push),
    .iq_full    (iq_full)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Model state: next block expected in program order, whether a block is
  // parked waiting for queue space, and whether the outstanding read is stale.
  logic [31:0] exp_pc;
  logic [31:0] stale_addr;
  bit          held;
  bit          stale;
  int unsigned lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5bd1e995;
  endfunction

  function automatic logic [64*N-1:0] exp_block(input logic [31:0] pc);
    logic [64*N-1:0] r;
    logic [31:0] p;
    for (int i = 0; i < N; i++) begin
      p = pc + 32'(4 * i);
      r[64*i +: 64] = {p, mem_word(p)};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    exp_pc = RST_PC;
    held   = 1'b0;
    stale  = 1'b0;
    stale_addr = '0;
    lat    = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req",   imem_req,  1'b0);
    check("rst_push",  iq_push,   1'b0);
    check("rst_addr",  imem_addr, RST_PC);
    check("rst_wdata", iq_wdata,  '0);
  endtask

  task automatic drive_random();
    imem_resp = 1'b0;
    if (imem_req) begin
      if (lat == 0) begin
        imem_resp = 1'b1;
        lat = $urandom_range(0, 3);
      end else begin
        lat--;
      end
    end
    if (imem_resp) imem_rdata = {mem_word(imem_addr + 32'd4), mem_word(imem_addr)};
    else           imem_rdata = {$urandom, $urandom};
    iq_full    = ($urandom_range(0, 99) < 35);
    mispredict = ($urandom_range(0, 99) < 8) && !(stale && imem_resp);
    if ($urandom_range(0, 9) == 0) redirect_pc = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
    else                           redirect_pc = RST_PC + 32'($urandom_range(0, 1023));
  endtask

  task automatic check_outputs();
    bit exp_push;
    exp_push = !mispredict && !iq_full && (held || (imem_resp && !stale));
    check("req",  imem_req, !held);
    check("push", iq_push,  exp_push);
    if (!held) check("addr", imem_addr, stale ? stale_addr : exp_pc);
    if (exp_push) check("wdata", iq_wdata, exp_block(exp_pc));
  endtask

  task automatic step_model();
    bit outstanding;
    outstanding = !held;
    if (mispredict) begin
      if (imem_resp) stale = 1'b0;
      else if (outstanding && !stale) begin
        stale = 1'b1;
        stale_addr = exp_pc;
      end
      exp_pc = redirect_pc & ~32'h3;
      held   = 1'b0;
    end else if (imem_resp && stale) begin
      stale = 1'b0;
    end else if (imem_resp && !held) begin
      if (!iq_full) exp_pc = exp_pc + 32'(4 * N);
      else          held   = 1'b1;
    end else if (held && !iq_full) begin
      held   = 1'b0;
      exp_pc = exp_pc + 32'(4 * N);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive_random();
    #1;
    check_outputs();
    step_model();
  endtask

  task automatic quiet_inputs();
    mispredict  = 1'b0;
    imem_resp   = 1'b0;
    iq_full     = 1'b0;
    redirect_pc = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    quiet_inputs();
    imem_rdata = '1;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      imem_rdata = {$urandom, $urandom};
      #1;
      check_reset_outputs();
    end
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3000) cycle();

    // Park the model in an outstanding-request phase before pulsing reset.
    for (int k = 0; k < 50 && held; k++) cycle();
    check("wait_bound", held, 1'b0);
    @(posedge clk);
    #2;
    quiet_inputs();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    repeat (1000) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
